io_oe_guard: RTL and testbench

- Parametrised successor to the single-bit emulator error checker.
- Monitors the design-under-test's bidirectional bus output enables (uio_oe) against a declared pin-direction mask.
- Filters transient mismatches, latches a sticky fault with the first offending pin index, and counts violation cycles.
- Drives a blinking fault LED. Sits in the FPGA emulator wrapper between the user top and the board LED/debug outputs.

---
 rtl/io_oe_guard_if.sv | 27 ++
 rtl/io_oe_guard.sv | 153 +++++++++++++++
 tb/tb_io_oe_guard.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/io_oe_guard_if.sv
// Bus between the user top and the output-enable guard: user-side
// enables/data and clear in, fault status and LED out.
interface io_oe_guard_if #(
    parameter int unsigned IO_W  = 8,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned PIN_W = (IO_W > 1) ? $clog2(IO_W) : 1;

    logic             clr_i;
    logic [IO_W-1:0]  uio_oe;
    logic [IO_W-1:0]  uio_out;
    logic             error_o;
    logic [PIN_W-1:0] err_pin_o;
    logic [IO_W-1:0]  err_data_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic             led_o;

    modport master (
        output clr_i, uio_oe, uio_out,
        input  error_o, err_pin_o, err_data_o, err_cnt_o, led_o
    );

    modport slave (
        input  clr_i, uio_oe, uio_out,
        output error_o, err_pin_o, err_data_o, err_cnt_o, led_o
    );
endinterface

// File: rtl/io_oe_guard.sv
// Output-enable guard: compares the user top's uio_oe against a declared
// direction mask, debounces violations, latches a sticky fault with the
// lowest offending pin and data snapshot, counts violating cycles and
// blinks a fault LED.
module io_oe_guard #(
    parameter int unsigned     IO_W       = 8,
    parameter logic [IO_W-1:0] EXPECT_OE  = '0,
    parameter bit              STRICT     = 1'b1,
    parameter int unsigned     FILTER_LEN = 2,
    parameter int unsigned     CNT_W      = 16,
    parameter int unsigned     BLINK_DIV  = 50_000_000
) (
    input  logic         clk,
    input  logic         nreset,
    io_oe_guard_if.slave bus
);
    localparam int unsigned PIN_W      = (IO_W > 1) ? $clog2(IO_W) : 1;
    localparam int unsigned FW         = $clog2(FILTER_LEN + 1);
    localparam int unsigned BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned BLINK_LAST = (BLINK_DIV > 0) ? BLINK_DIV - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IO_W-1:0]  oe_q, out_q;
    logic [IO_W-1:0]  v;
    logic             viol;
    logic [PIN_W-1:0] first_pin;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             error_q, error_d;
    logic [PIN_W-1:0] pin_q, pin_d;
    logic [IO_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             enter;

    // Input sampling stage; all checking works on the registered copy.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            oe_q  <= '0;
            out_q <= '0;
        end else begin
            oe_q  <= bus.uio_oe;
            out_q <= bus.uio_out;
        end
    end

    // Violation vector and lowest offending pin index.
    always_comb begin
        v         = STRICT ? (oe_q ^ EXPECT_OE) : (oe_q & ~EXPECT_OE);
        viol      = |v;
        first_pin = '0;
        for (int i = int'(IO_W) - 1; i >= 0; i--) begin
            if (v[i]) first_pin = PIN_W'(i);
        end
    end

    // Next-state and next-output logic; clear overrides everything.
    always_comb begin
        state_d = state_q;
        fcnt_d  = '0;
        bcnt_d  = bcnt_q;
        error_d = error_q;
        pin_d   = pin_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        enter   = 1'b0;

        if (viol) begin
            fcnt_d = (fcnt_q == FW'(FILTER_LEN)) ? fcnt_q : fcnt_q + 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (viol) begin
                    if (fcnt_q == FW'(FILTER_LEN - 1)) enter = 1'b1;
                    else                               state_d = PENDING;
                end
            end
            PENDING: begin
                if (!viol)                                 state_d = IDLE;
                else if (fcnt_q == FW'(FILTER_LEN - 1))    enter = 1'b1;
            end
            FAULT: begin
                if (BLINK_DIV == 0) begin
                    led_d = 1'b1;
                end else if (bcnt_q == BW'(BLINK_LAST)) begin
                    bcnt_d = '0;
                    led_d  = ~led_q;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter) begin
            state_d = FAULT;
            error_d = 1'b1;
            pin_d   = first_pin;
            data_d  = out_q;
            bcnt_d  = '0;
            led_d   = 1'b1;
        end

        if (bus.clr_i) begin
            state_d = IDLE;
            fcnt_d  = '0;
            bcnt_d  = '0;
            error_d = 1'b0;
            pin_d   = '0;
            data_d  = '0;
            cnt_d   = '0;
            led_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
            error_q <= 1'b0;
            pin_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
            error_q <= error_d;
            pin_q   <= pin_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    assign bus.error_o    = error_q;
    assign bus.err_pin_o  = pin_q;
    assign bus.err_data_o = data_q;
    assign bus.err_cnt_o  = cnt_q;
    assign bus.led_o      = led_q;
endmodule

// File: tb/tb_io_oe_guard.sv
// Randomized bench for io_oe_guard: two instances (strict and lenient
// direction checking) share one stimulus stream; a behavioural model
// pushes expected outputs per edge and a monitor compares at negedge.
module tb_io_oe_guard;
    localparam logic [7:0] EXP      = 8'h0F;
    localparam int         A_FLEN   = 2;
    localparam int         A_CNTW   = 4;
    localparam int         A_BDIV   = 4;
    localparam int         B_FLEN   = 3;
    localparam int         B_CNTW   = 3;
    localparam int         B_BDIV   = 0;
    localparam int         N_CYC    = 3000;

    typedef struct {
        int         run;
        bit         fault;
        int         pin;
        logic [7:0] data;
        int         cnt;
        int         since;
    } model_t;

    typedef struct {
        bit         error;
        int         pin;
        logic [7:0] data;
        int         cnt;
        bit         led;
    } exp_t;

    logic       clk = 1'b0;
    logic       nreset;
    logic       clr;
    logic [7:0] oe, dout;

    io_oe_guard_if #(.IO_W(8), .CNT_W(A_CNTW)) bus_a ();
    io_oe_guard_if #(.IO_W(8), .CNT_W(B_CNTW)) bus_b ();

    assign bus_a.clr_i   = clr;
    assign bus_a.uio_oe  = oe;
    assign bus_a.uio_out = dout;
    assign bus_b.clr_i   = clr;
    assign bus_b.uio_oe  = oe;
    assign bus_b.uio_out = dout;

    io_oe_guard #(.IO_W(8), .EXPECT_OE(EXP), .STRICT(1'b1), .FILTER_LEN(A_FLEN),
                  .CNT_W(A_CNTW), .BLINK_DIV(A_BDIV))
        u_a (.clk(clk), .nreset(nreset), .bus(bus_a));

    io_oe_guard #(.IO_W(8), .EXPECT_OE(EXP), .STRICT(1'b0), .FILTER_LEN(B_FLEN),
                  .CNT_W(B_CNTW), .BLINK_DIV(B_BDIV))
        u_b (.clk(clk), .nreset(nreset), .bus(bus_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    model_t ma, mb;
    logic [7:0] prev_oe, prev_out;

    function automatic model_t model_zero();
        model_t m;
        m.run = 0; m.fault = 1'b0; m.pin = 0; m.data = '0; m.cnt = 0; m.since = 0;
        return m;
    endfunction

    // One clock edge of the guard, in terms of the sampled value seen
    // during the cycle before that edge.
    function automatic model_t model_step(model_t m, logic [7:0] s_oe, logic [7:0] s_out,
                                          bit c, bit strict, int flen, int cntw);
        logic [7:0] v;
        model_t r = m;
        int cmax = (1 << cntw) - 1;
        v = strict ? (s_oe ^ EXP) : (s_oe & ~EXP);
        if (c) return model_zero();
        if (v != 0) begin
            r.run = r.run + 1;
            if (r.cnt < cmax) r.cnt = r.cnt + 1;
        end else begin
            r.run = 0;
        end
        if (r.fault) begin
            r.since = r.since + 1;
        end else if (r.run >= flen) begin
            r.fault = 1'b1;
            r.since = 0;
            r.data  = s_out;
            r.pin   = 0;
            for (int i = 7; i >= 0; i--) if (v[i]) r.pin = i;
        end
        return r;
    endfunction

    function automatic exp_t model_view(model_t m, int bdiv);
        exp_t e;
        e.error = m.fault;
        e.pin   = m.pin;
        e.data  = m.data;
        e.cnt   = m.cnt;
        e.led   = m.fault && (bdiv == 0 || ((m.since / bdiv) % 2 == 0));
        return e;
    endfunction

    // Advance the model on the next edge and queue the expected outputs.
    task automatic tick(input bit arst);
        @(posedge clk);
        if (!nreset) begin
            ma = model_zero(); mb = model_zero();
            prev_oe = '0; prev_out = '0;
        end else begin
            ma = model_step(ma, prev_oe, prev_out, clr, 1'b1, A_FLEN, A_CNTW);
            mb = model_step(mb, prev_oe, prev_out, clr, 1'b0, B_FLEN, B_CNTW);
            prev_oe  = oe;
            prev_out = dout;
        end
        if (arst) begin
            ma = model_zero(); mb = model_zero();
            prev_oe = '0; prev_out = '0;
        end
        q_a.push_back(model_view(ma, A_BDIV));
        q_b.push_back(model_view(mb, B_BDIV));
    endtask

    task automatic compare(input string name, input bit err, input int pin,
                           input logic [7:0] data, input int cnt, input bit led, input exp_t e);
        n_checks++;
        if (err === e.error && pin == e.pin && data === e.data && cnt == e.cnt && led === e.led) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t got err=%0b pin=%0d data=%02h cnt=%0d led=%0b exp err=%0b pin=%0d data=%02h cnt=%0d led=%0b",
                     name, $time, err, pin, data, cnt, led,
                     e.error, e.pin, e.data, e.cnt, e.led);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                compare("dut_strict", bus_a.error_o, int'(bus_a.err_pin_o), bus_a.err_data_o,
                        int'(bus_a.err_cnt_o), bus_a.led_o, e);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                compare("dut_lenient", bus_b.error_o, int'(bus_b.err_pin_o), bus_b.err_data_o,
                        int'(bus_b.err_cnt_o), bus_b.led_o, e);
            end
        end
    end

    // Stimulus: held random enable patterns, sparse clears and resets.
    initial begin
        int hold = 0;
        int rst_hold = 0;
        bit arst;
        int r;
        nreset = 1'b0;
        clr    = 1'b0;
        oe     = EXP;
        dout   = 8'h00;
        ma = model_zero(); mb = model_zero();
        prev_oe = '0; prev_out = '0;
        repeat (3) tick(1'b0);
        #1 nreset = 1'b1;

        for (int c = 0; c < N_CYC; c++) begin
            arst = nreset && c > 20 &&
                   (c == 700 || c == 1900 || $urandom_range(0, 399) == 0);
            tick(arst);
            #1;
            if (c < 20) begin
                oe  = EXP;
                clr = 1'b0;
            end else begin
                if (hold == 0) begin
                    r = $urandom_range(0, 9);
                    case (r)
                        0, 1, 2, 3: oe = EXP;
                        4, 5:       oe = 8'h07;
                        6:          oe = 8'h28;
                        7:          oe = EXP | (8'h01 << $urandom_range(4, 7));
                        default:    oe = 8'($urandom());
                    endcase
                    dout = 8'($urandom());
                    hold = $urandom_range(1, 8);
                end else begin
                    hold--;
                end
                clr = ($urandom_range(0, 29) == 0);
            end
            if (!nreset) begin
                if (rst_hold == 0) nreset = 1'b1;
                else rst_hold--;
            end
            #1;
            if (arst) begin
                nreset   = 1'b0;
                rst_hold = 1;
            end
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
        else $display("FAIL queue_drain got %0d/%0d pending required 0", q_a.size(), q_b.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
